// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types, constants and the rotating-priority pick function for rr_mux_arbiter.
package rr_mux_arbiter_pkg;

  typedef enum logic {EMPTY, FULL} arb_state_t;

  localparam int              CNT_W     = 8;
  localparam logic [CNT_W-1:0] CNT_MAX  = 8'hFF;
  localparam int              MAX_REQ   = 16;
  localparam int              MAX_PTR_W = 4;

  // One-hot winner: first set bit of valid searching ptr, ptr+1, ... modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0]   valid,
    input logic [MAX_PTR_W-1:0] ptr,
    input int unsigned          n
  );
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int unsigned        idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && valid[idx[MAX_PTR_W-1:0]]) begin
        gnt[idx[MAX_PTR_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Rotating-priority one-hot selector; combinational, zero latency, no backpressure of its own.
module rr_pick_onehot #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot
);
  import rr_mux_arbiter_pkg::*;

  logic [MAX_REQ-1:0] pick;
  logic               unused_pick;

  assign pick        = rr_pick(MAX_REQ'(valid), MAX_PTR_W'(ptr), N_REQ);
  assign onehot      = pick[N_REQ-1:0];
  assign unused_pick = ^pick;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin N_REQ:1 arbiter loading one output register: 1-cycle latency, 1 word/cycle; a stall holds
// out_* stable and drops every req_ready. `RR_ARB_GNT_CNT_EN adds saturating per-requester grant counters.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = 8,
  localparam int PTR_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
`ifdef RR_ARB_GNT_CNT_EN
  output logic [PTR_W-1:0]        out_src,
  input  logic                    cnt_clr,
  output logic [N_REQ*CNT_W-1:0]  gnt_cnt
`else
  output logic [PTR_W-1:0]        out_src
`endif
);

  arb_state_t        state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  nxt_ptr;
  logic [N_REQ-1:0]  win_oh;
  logic [DATA_W-1:0] win_dat;
  logic              load;

  rr_pick_onehot #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .valid  (req_valid),
    .ptr    (rr_ptr),
    .onehot (win_oh)
  );

  // rst_n gates load so no requester sees a grant while the block is held in reset.
  assign load      = rst_n && (state == EMPTY || out_ready) && (|req_valid);
  assign req_ready = load ? win_oh : '0;

  always_comb begin
    win_idx = '0;
    win_dat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) begin
        win_idx = PTR_W'(i);
        win_dat = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign nxt_ptr = (win_idx == PTR_W'(N_REQ-1)) ? '0 : win_idx + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= win_dat;
            out_src   <= win_idx;
            rr_ptr    <= nxt_ptr;
          end
        end
        FULL: begin
          if (load) begin
            out_data <= win_dat;
            out_src  <= win_idx;
            rr_ptr   <= nxt_ptr;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef RR_ARB_GNT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (cnt_clr) begin
          gnt_cnt[i*CNT_W +: CNT_W] <= '0;
        end else if (load && win_oh[i] && gnt_cnt[i*CNT_W +: CNT_W] != CNT_MAX) begin
          gnt_cnt[i*CNT_W +: CNT_W] <= gnt_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: reference round-robin model feeds an expected-word queue.
module tb_rr_mux_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam logic [N*W-1:0] DIR_DATA = 32'h4332_2110;

  typedef struct {
    int           src;
    logic [W-1:0] dat;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [1:0]     out_src;
`ifdef RR_ARB_GNT_CNT_EN
  logic           cnt_clr;
  logic [N*8-1:0] gnt_cnt;
`endif

  rr_mux_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
`ifdef RR_ARB_GNT_CNT_EN
    .out_src   (out_src),
    .cnt_clr   (cnt_clr),
    .gnt_cnt   (gnt_cnt)
`else
    .out_src   (out_src)
`endif
  );

  int   n_chk;
  int   n_fail;
  bit   mon_en;
  int   m_ptr;
  bit   m_occ;
  exp_t exp_q[$];
  int   seen_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, required completion", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: first valid requester scanning from the pointer, wrapping modulo N.
  function automatic int ref_winner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Called at posedge+1: drive one cycle, check grants, then advance the model past the edge.
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy);
    bit   ld;
    int   win;
    exp_t e;
    req_valid = v;
    req_data  = d;
    out_ready = ordy;
    win = ref_winner(v, m_ptr);
    ld  = (!m_occ || ordy) && (win >= 0);
    #3;
    chk("req_ready", 32'(req_ready), ld ? (32'd1 << win) : 32'd0);
    for (int i = 0; i < N; i++) if (req_ready[i]) seen_q.push_back(i);
    @(posedge clk);
    #1;
    if (ld) begin
      e.src = win;
      e.dat = d[win*W +: W];
      exp_q.push_back(e);
      m_ptr = (win + 1) % N;
      m_occ = 1'b1;
    end else if (m_occ && ordy) begin
      m_occ = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] held;
    bit           stalled;
    exp_t         e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stalled = 1'b0;
      end else begin
        chk("out_valid", 32'(out_valid), 32'(m_occ));
        if (stalled) chk("stall_hold", 32'(out_data), 32'(held));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard: got word 0x%0h, expected no word", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e.dat));
            chk("out_src", 32'(out_src), 32'(e.src));
          end
        end
        stalled = out_valid && !out_ready;
        held    = out_data;
      end
    end
  end

  initial begin
    int exp_t2[5];
    exp_t2 = '{0, 1, 2, 3, 0};
    n_chk = 0; n_fail = 0; mon_en = 1'b0; m_ptr = 0; m_occ = 1'b0;
`ifdef RR_ARB_GNT_CNT_EN
    cnt_clr = 1'b0;
`endif
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = DIR_DATA;
    out_ready = 1'b1;

    // Reset values, with requests present to show grants are gated.
    #7;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    req_valid = '0;
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_req_ready", 32'(req_ready), 32'd0);
    mon_en = 1'b1;

    // All requesters valid, full throughput.
    seen_q.delete();
    for (int i = 0; i < 5; i++) step(4'hF, DIR_DATA, 1'b1);
    chk("t2_grant_count", 32'(seen_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen_q.size(); i++) chk("t2_grant", 32'(seen_q[i]), 32'(exp_t2[i]));

    // Stall with 1 and 3 requesting.
    step(4'h0, DIR_DATA, 1'b1);
    seen_q.delete();
    step(4'b1010, DIR_DATA, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b1010, DIR_DATA, 1'b0);
      chk("t3_held_data", 32'(out_data), 32'h21);
    end
    step(4'b1010, DIR_DATA, 1'b1);
    chk("t3_after_release", 32'(out_data), 32'h43);
    chk("t3_grant_count", 32'(seen_q.size()), 32'd2);
    if (seen_q.size() == 2) begin
      chk("t3_first_grant", 32'(seen_q[0]), 32'd1);
      chk("t3_second_grant", 32'(seen_q[1]), 32'd3);
    end

    // Single requester granted every cycle; pointer ends at 3.
    step(4'h0, DIR_DATA, 1'b1);
    seen_q.delete();
    for (int i = 0; i < 5; i++) step(4'b0100, DIR_DATA, 1'b1);
    chk("t4_grant_count", 32'(seen_q.size()), 32'd5);
    for (int i = 0; i < seen_q.size(); i++) chk("t4_grant", 32'(seen_q[i]), 32'd2);
    seen_q.delete();
    step(4'hF, DIR_DATA, 1'b1);
    chk("t4_wrap_grant", (seen_q.size() > 0) ? 32'(seen_q[0]) : 32'hFFFF_FFFF, 32'd3);

    // Reset in the middle of a held word.
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    m_occ = 1'b0;
    m_ptr = 0;
    req_valid = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_no_glitch", 32'(out_valid), 32'd0);
    mon_en = 1'b1;
    seen_q.delete();
    step(4'hF, DIR_DATA, 1'b1);
    chk("t5_first_grant", (seen_q.size() > 0) ? 32'(seen_q[0]) : 32'hFFFF_FFFF, 32'd0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), 32'($urandom), ($urandom_range(0, 3) != 0));
    end

`ifdef RR_ARB_GNT_CNT_EN
    for (int i = 0; i < 300; i++) step(4'b0010, DIR_DATA, 1'b1);
    chk("cnt_saturated", 32'(gnt_cnt[15:8]), 32'd255);
    cnt_clr = 1'b1;
    step(4'b0010, DIR_DATA, 1'b1);
    cnt_clr = 1'b0;
    chk("cnt_clr_priority", 32'(gnt_cnt[15:8]), 32'd0);
`endif

    step(4'h0, DIR_DATA, 1'b1);
    step(4'h0, DIR_DATA, 1'b1);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
